// File: rtl/divider_unsigned_seq.sv
// Multi-cycle unsigned 32-bit restoring divider with valid/ready on both sides.
// Trial subtractions go through a carry-lookahead adder as a + ~b + 1.

module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [3:0]  gg;
  logic [3:0]  pp;
  logic        grp_g;
  logic        grp_p;

  assign g = a & b;
  assign p = a ^ b;

  // Eight 4-bit lookahead groups; group carries chain through group G/P terms.
  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    c     = '0;
    gg    = '0;
    pp    = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    c[0]  = cin;
    for (int j = 0; j < 8; j++) begin
      gg = g[4*j +: 4];
      pp = p[4*j +: 4];
      c[4*j+1] = gg[0] | (pp[0] & c[4*j]);
      c[4*j+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[4*j]);
      c[4*j+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & c[4*j]);
      grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
      grp_p = &pp;
      c[4*j+4] = grp_g | (grp_p & c[4*j]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

module divider_unsigned_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_busy
);

  localparam int K     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        qreg_q;
  logic [31:0]        rem_q;
  logic [31:0]        divisor_q;
  logic [31:0]        divisor_inv;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        step_qreg;
  logic [31:0]        step_rem;

  assign divisor_inv = ~divisor_q;

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
    logic [31:0] rem_in;
    logic [31:0] q_in;
    logic [31:0] rem_out;
    logic [31:0] q_out;
    logic [32:0] s;
    logic [31:0] diff;
    logic        carry;
    logic        ge;

    if (j == 0) begin : g_first
      assign rem_in = rem_q;
      assign q_in   = qreg_q;
    end else begin : g_chain
      assign rem_in = g_step[j-1].rem_out;
      assign q_in   = g_step[j-1].q_out;
    end

    assign s = {rem_in, q_in[31]};

    cla u_cla (
      .a    (s[31:0]),
      .b    (divisor_inv),
      .cin  (1'b1),
      .sum  (diff),
      .cout (carry)
    );

    // Carry-out of a + ~b + 1 is exactly (a >= b); s[32] covers divisors >= 2^31.
    assign ge      = s[32] | carry;
    assign rem_out = ge ? diff : s[31:0];
    assign q_out   = {q_in[30:0], ge};
  end

  assign step_rem  = g_step[BITS_PER_CYCLE-1].rem_out;
  assign step_qreg = g_step[BITS_PER_CYCLE-1].q_out;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(K - 1)) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are cleared by reset too, so a discarded run leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      qreg_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            qreg_q    <= i_dividend;
            divisor_q <= i_divisor;
            rem_q     <= '0;
            cnt_q     <= '0;
          end
        end
        RUN: begin
          qreg_q <= step_qreg;
          rem_q  <= step_rem;
          cnt_q  <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while rst is held, even before the reset edge lands.
  always_comb begin
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_busy      = 1'b0;
    o_quotient  = '0;
    o_remainder = '0;
    if (!rst) begin
      case (state_q)
        IDLE: o_ready = 1'b1;
        RUN:  o_busy  = 1'b1;
        DONE: begin
          o_valid     = 1'b1;
          o_quotient  = qreg_q;
          o_remainder = rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule
